lsu_core: RTL and testbench

LSU_CORE -- requirements
Module: lsu_core

---
 rtl/lsu_core_if.sv | 44 ++++
 rtl/lsu_core.sv | 255 +++++++++++++++++++++++++
 tb/tb_lsu_core.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_core_if.sv
// lsu_core_if -- request/memory/response bundle for the load/store unit.
//
// Signals (directions as seen from the LSU, i.e. the slave modport):
//   request  : i_req_valid, o_req_ready, i_is_store, i_funct3[2:0],
//              i_addr[31:0], i_wdata[31:0]
//   memory   : o_mem_req, o_mem_we, o_mem_addr[31:0], o_mem_be[3:0],
//              o_mem_wdata[31:0], i_mem_ack, i_mem_rdata[31:0]
//   response : o_rsp_valid, o_rsp_data[31:0], o_bus_err, o_misaligned
//
// slave  : the LSU itself.
// master : the environment (execute stage plus memory model).
interface lsu_core_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_bus_err;
  logic        o_misaligned;

  modport slave (
    input  i_req_valid, i_is_store, i_funct3, i_addr, i_wdata,
    input  i_mem_ack, i_mem_rdata,
    output o_req_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be,
    output o_mem_wdata, o_rsp_valid, o_rsp_data, o_bus_err, o_misaligned
  );

  modport master (
    output i_req_valid, i_is_store, i_funct3, i_addr, i_wdata,
    output i_mem_ack, i_mem_rdata,
    input  o_req_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be,
    input  o_mem_wdata, o_rsp_valid, o_rsp_data, o_bus_err, o_misaligned
  );
endinterface

// File: rtl/lsu_core.sv
// lsu_core -- single-outstanding load/store unit.
//
// Accepts one load/store from the execute stage (IDLE), issues a single
// word-aligned memory access with byte enables and lane-replicated store
// data (BUSY), then returns a one-cycle response pulse (DONE). Load data
// is shifted down to the addressed lane and sign/zero extended. A memory
// access that sees no ack for TIMEOUT cycles completes with o_bus_err.
//
// Parameters:
//   TIMEOUT  BUSY cycles awaiting i_mem_ack before bus error (2..255).
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_rst    synchronous active-high reset
//   bus      lsu_core_if.slave (request, memory and response signals)
// Configuration:
//   LSU_MISALIGN_TRAP_EN  defined: misaligned H/W requests complete at once
//                         with o_misaligned=1 and no memory access.
//                         undefined: o_misaligned stays 0 and the address is
//                         forced to the natural alignment of the access.
module lsu_core #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic      i_clk,
  input  logic      i_rst,
  lsu_core_if.slave bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  // Counter value during the last BUSY cycle before a timeout.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r, state_nxt;
  logic [7:0]  cnt_r, cnt_nxt;
  logic [2:0]  f3_r, f3_nxt;
  logic [1:0]  lo_r, lo_nxt;
  logic [1:0]  req_lo_s;

  logic        ready_r;
  logic        mem_req_r, mem_req_nxt;
  logic        mem_we_r, mem_we_nxt;
  logic [31:0] mem_addr_r, mem_addr_nxt;
  logic [3:0]  mem_be_r, mem_be_nxt;
  logic [31:0] mem_wdata_r, mem_wdata_nxt;
  logic        rsp_valid_r, rsp_valid_nxt;
  logic [31:0] rsp_data_r, rsp_data_nxt;
  logic        bus_err_r, bus_err_nxt;
  logic        misaligned_r, misaligned_nxt;

  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    case (f3)
      3'b001, 3'b101: m = lo[0];
      3'b010:         m = |lo;
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

  // Natural alignment of the low address bits for the access size.
  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] r;
    case (f3)
      3'b001, 3'b101: r = {lo[1], 1'b0};
      3'b010:         r = 2'b00;
      default:        r = lo;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      3'b000, 3'b100: be = 4'b0001 << lo;
      3'b001, 3'b101: be = 4'b0011 << {lo[1], 1'b0};
      3'b010:         be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3)
      3'b000, 3'b100: r = {4{wd[7:0]}};
      3'b001, 3'b101: r = {2{wd[15:0]}};
      default:        r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rd >> {lo, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic; memory outputs are zero outside BUSY.
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    f3_nxt         = f3_r;
    lo_nxt         = lo_r;
    mem_req_nxt    = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = 32'd0;
    mem_be_nxt     = 4'd0;
    mem_wdata_nxt  = 32'd0;
    rsp_valid_nxt  = 1'b0;
    rsp_data_nxt   = 32'd0;
    bus_err_nxt    = 1'b0;
    misaligned_nxt = 1'b0;
    req_lo_s       = align_lo(bus.i_funct3, bus.i_addr[1:0]);

    case (state_r)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          if (!f3_legal(bus.i_funct3)) begin
            state_nxt     = ST_DONE;
            rsp_valid_nxt = 1'b1;
            bus_err_nxt   = 1'b1;
          end else if (TRAP_EN && f3_misaligned(bus.i_funct3, bus.i_addr[1:0])) begin
            state_nxt      = ST_DONE;
            rsp_valid_nxt  = 1'b1;
            misaligned_nxt = 1'b1;
          end else begin
            // Without the trap, req_lo_s already carries the forced alignment.
            state_nxt     = ST_BUSY;
            cnt_nxt       = 8'd0;
            f3_nxt        = bus.i_funct3;
            lo_nxt        = req_lo_s;
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = bus.i_is_store;
            mem_addr_nxt  = {bus.i_addr[31:2], 2'b00};
            mem_be_nxt    = byte_en(bus.i_funct3, req_lo_s);
            mem_wdata_nxt = store_lanes(bus.i_funct3, bus.i_wdata);
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Ack is checked first so an ack in the final cycle beats the timeout.
        if (bus.i_mem_ack) begin
          state_nxt     = ST_DONE;
          rsp_valid_nxt = 1'b1;
          if (mem_we_r) begin
            rsp_data_nxt = 32'd0;
          end else begin
            rsp_data_nxt = load_extend(f3_r, lo_r, bus.i_mem_rdata);
          end
        end else if (cnt_r == CNT_LAST) begin
          state_nxt     = ST_DONE;
          rsp_valid_nxt = 1'b1;
          bus_err_nxt   = 1'b1;
        end else begin
          cnt_nxt       = cnt_r + 8'd1;
          mem_req_nxt   = mem_req_r;
          mem_we_nxt    = mem_we_r;
          mem_addr_nxt  = mem_addr_r;
          mem_be_nxt    = mem_be_r;
          mem_wdata_nxt = mem_wdata_r;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, timeout counter and latched access context.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      f3_r    <= 3'd0;
      lo_r    <= 2'd0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      f3_r    <= f3_nxt;
      lo_r    <= lo_nxt;
    end
  end

  // Registered outputs; ready tracks whether the next state is IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_r      <= 1'b1;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_be_r     <= 4'd0;
      mem_wdata_r  <= 32'd0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 32'd0;
      bus_err_r    <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      ready_r      <= (state_nxt == ST_IDLE);
      mem_req_r    <= mem_req_nxt;
      mem_we_r     <= mem_we_nxt;
      mem_addr_r   <= mem_addr_nxt;
      mem_be_r     <= mem_be_nxt;
      mem_wdata_r  <= mem_wdata_nxt;
      rsp_valid_r  <= rsp_valid_nxt;
      rsp_data_r   <= rsp_data_nxt;
      bus_err_r    <= bus_err_nxt;
      misaligned_r <= misaligned_nxt;
    end
  end

  assign bus.o_req_ready  = ready_r;
  assign bus.o_mem_req    = mem_req_r;
  assign bus.o_mem_we     = mem_we_r;
  assign bus.o_mem_addr   = mem_addr_r;
  assign bus.o_mem_be     = mem_be_r;
  assign bus.o_mem_wdata  = mem_wdata_r;
  assign bus.o_rsp_valid  = rsp_valid_r;
  assign bus.o_rsp_data   = rsp_data_r;
  assign bus.o_bus_err    = bus_err_r;
  assign bus.o_misaligned = misaligned_r;

endmodule

// File: tb/tb_lsu_core.sv
// tb_lsu_core -- self-checking bench for lsu_core.
// Directed scenarios followed by randomized transactions, each compared
// against a size/offset arithmetic model of the load/store rules.
// Honors LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_core;
  localparam int unsigned TO = 6;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  lsu_core_if bus ();

  lsu_core #(.TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Access size in bytes; 0 marks an illegal funct3.
  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  task automatic scramble_req();
    bus.i_req_valid = 1'($urandom_range(0, 1));
    bus.i_is_store  = 1'($urandom_range(0, 1));
    bus.i_funct3    = 3'($urandom_range(0, 7));
    bus.i_addr      = $urandom();
    bus.i_wdata     = $urandom();
  endtask

  // One full transaction; ack_cyc = BUSY cycle (1-based) carrying the ack,
  // 0 or > TO means no ack. Returns the observed bus/response values.
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int ack_cyc,
                     output logic [31:0] o_addr, output logic [3:0] o_be,
                     output logic [31:0] o_wd, output logic o_we,
                     output logic [31:0] o_rsp, output logic o_err,
                     output logic o_mis, output logic o_req_seen);
    int unsigned size, off, eff;
    int          done_cyc;
    bit          legal, mis, goes_mem, e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rsp, mask, v;

    size  = acc_size(f3);
    legal = (size != 0);
    off   = a % 4;
    mis   = 1'b0;
    eff   = 0;
    e_be  = 4'd0;
    e_wd  = wd;
    v     = 32'd0;
    if (legal) begin
      mis  = (off % size) != 0;
      eff  = off - (off % size);
      e_be = 4'(((32'd1 << size) - 32'd1) << eff);
      if (size == 1)      e_wd = (wd & 32'h0000_00FF) * 32'h0101_0101;
      else if (size == 2) e_wd = (wd & 32'h0000_FFFF) * 32'h0001_0001;
      else                e_wd = wd;
      if (size == 4) mask = 32'hFFFF_FFFF;
      else           mask = (32'd1 << (8 * size)) - 32'd1;
      v = (rd >> (8 * eff)) & mask;
      if (f3 < 3'd4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
    end
    goes_mem = legal && !(mis && TRAP);
    if (ack_cyc >= 1 && ack_cyc <= int'(TO)) begin
      done_cyc = ack_cyc;
      e_err    = 1'b0;
      e_rsp    = st ? 32'd0 : v;
    end else begin
      done_cyc = int'(TO);
      e_err    = 1'b1;
      e_rsp    = 32'd0;
    end

    @(negedge clk);
    chk1("idle_ready", bus.o_req_ready, 1'b1);
    chk1("idle_rsp_valid", bus.o_rsp_valid, 1'b0);
    bus.i_req_valid = 1'b1;
    bus.i_is_store  = st;
    bus.i_funct3    = f3;
    bus.i_addr      = a;
    bus.i_wdata     = wd;
    bus.i_mem_ack   = 1'b0;
    @(negedge clk);
    o_req_seen = bus.o_mem_req;
    o_addr     = bus.o_mem_addr;
    o_be       = bus.o_mem_be;
    o_wd       = bus.o_mem_wdata;
    o_we       = bus.o_mem_we;
    if (!goes_mem) begin
      chk1("early_rsp_valid", bus.o_rsp_valid, 1'b1);
      chk1("early_mem_req", bus.o_mem_req, 1'b0);
      chk1("early_bus_err", bus.o_bus_err, !legal);
      chk1("early_misaligned", bus.o_misaligned, legal && mis && TRAP);
      chk("early_rsp_data", bus.o_rsp_data, 32'd0);
      chk1("early_ready", bus.o_req_ready, 1'b0);
    end else begin
      for (int c = 1; c <= done_cyc; c++) begin
        chk1("busy_mem_req", bus.o_mem_req, 1'b1);
        chk1("busy_we", bus.o_mem_we, st);
        chk("busy_addr", bus.o_mem_addr, {a[31:2], 2'b00});
        chk("busy_be", {28'd0, bus.o_mem_be}, {28'd0, e_be});
        chk("busy_wdata", bus.o_mem_wdata, e_wd);
        chk1("busy_rsp_valid", bus.o_rsp_valid, 1'b0);
        chk("busy_rsp_data", bus.o_rsp_data, 32'd0);
        chk1("busy_bus_err", bus.o_bus_err, 1'b0);
        chk1("busy_ready", bus.o_req_ready, 1'b0);
        o_req_seen      = o_req_seen | bus.o_mem_req;
        scramble_req();
        bus.i_mem_ack   = (c == ack_cyc);
        bus.i_mem_rdata = (c == ack_cyc) ? rd : $urandom();
        @(negedge clk);
      end
      chk1("done_rsp_valid", bus.o_rsp_valid, 1'b1);
      chk1("done_mem_req", bus.o_mem_req, 1'b0);
      chk1("done_bus_err", bus.o_bus_err, e_err);
      chk1("done_misaligned", bus.o_misaligned, 1'b0);
      chk("done_rsp_data", bus.o_rsp_data, e_rsp);
      chk1("done_ready", bus.o_req_ready, 1'b0);
    end
    o_rsp = bus.o_rsp_data;
    o_err = bus.o_bus_err;
    o_mis = bus.o_misaligned;
    // Stray request and ack in DONE must have no effect.
    scramble_req();
    bus.i_mem_ack   = 1'($urandom_range(0, 1));
    bus.i_mem_rdata = $urandom();
    @(negedge clk);
    chk1("after_rsp_valid", bus.o_rsp_valid, 1'b0);
    chk1("after_mem_req", bus.o_mem_req, 1'b0);
    chk1("after_ready", bus.o_req_ready, 1'b1);
    chk("after_rsp_data", bus.o_rsp_data, 32'd0);
    bus.i_req_valid = 1'b0;
    bus.i_mem_ack   = 1'b0;
  endtask

  initial begin
    logic [31:0] r_addr, r_wd, r_rsp, rd;
    logic [3:0]  r_be;
    logic        r_we, r_err, r_mis, r_seen, st;
    logic [2:0]  f3;
    logic [2:0]  ld_tab [8];
    logic [2:0]  st_tab [4];
    ld_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    st_tab = '{3'd0, 3'd1, 3'd2, 3'd3};

    rst             = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_is_store  = 1'b0;
    bus.i_funct3    = 3'd0;
    bus.i_addr      = 32'd0;
    bus.i_wdata     = 32'd0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk1("rst_ready", bus.o_req_ready, 1'b1);
    chk1("rst_mem_req", bus.o_mem_req, 1'b0);
    chk1("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.o_rsp_data, 32'd0);
    chk1("rst_bus_err", bus.o_bus_err, 1'b0);
    chk1("rst_misaligned", bus.o_misaligned, 1'b0);
    rst = 1'b0;

    // LB from byte lane 3, sign-extended.
    txn(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80AA_BBCC, 1,
        r_addr, r_be, r_wd, r_we, r_rsp, r_err, r_mis, r_seen);
    chk("lb_be", {28'd0, r_be}, 32'h0000_0008);
    chk("lb_addr", r_addr, 32'h0000_1000);
    chk("lb_rsp", r_rsp, 32'hFFFF_FF80);

    // SH to the upper halfword.
    txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'hDEAD_BEEF, 2,
        r_addr, r_be, r_wd, r_we, r_rsp, r_err, r_mis, r_seen);
    chk1("sh_we", r_we, 1'b1);
    chk("sh_be", {28'd0, r_be}, 32'h0000_000C);
    chk("sh_wdata", r_wd, 32'h5678_5678);
    chk("sh_rsp", r_rsp, 32'd0);

    // LW without ack times out; ack in the final BUSY cycle wins.
    txn(1'b0, 3'b010, 32'h0000_3000, 32'd0, 32'h1111_2222, 0,
        r_addr, r_be, r_wd, r_we, r_rsp, r_err, r_mis, r_seen);
    chk1("lw_timeout_err", r_err, 1'b1);
    txn(1'b0, 3'b010, 32'h0000_3000, 32'd0, 32'h1111_2222, int'(TO),
        r_addr, r_be, r_wd, r_we, r_rsp, r_err, r_mis, r_seen);
    chk1("lw_lastack_err", r_err, 1'b0);
    chk("lw_lastack_rsp", r_rsp, 32'h1111_2222);

    // LHU at an odd address.
    txn(1'b0, 3'b101, 32'h0000_0001, 32'd0, 32'h0000_F00D, 1,
        r_addr, r_be, r_wd, r_we, r_rsp, r_err, r_mis, r_seen);
    if (TRAP) begin
      chk1("lhu_trap_mis", r_mis, 1'b1);
      chk1("lhu_trap_noreq", r_seen, 1'b0);
    end else begin
      chk("lhu_addr", r_addr, 32'h0000_0000);
      chk("lhu_be", {28'd0, r_be}, 32'h0000_0003);
      chk("lhu_rsp", r_rsp, 32'h0000_F00D);
    end

    // Reset in the second BUSY cycle, then a stale ack.
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_is_store  = 1'b0;
    bus.i_funct3    = 3'b010;
    bus.i_addr      = 32'h0000_3000;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    chk1("rstbusy_req1", bus.o_mem_req, 1'b1);
    @(negedge clk);
    chk1("rstbusy_req2", bus.o_mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst             = 1'b0;
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'hCAFE_F00D;
    chk1("rstbusy_ready", bus.o_req_ready, 1'b1);
    chk1("rstbusy_mem_req", bus.o_mem_req, 1'b0);
    chk1("rstbusy_rsp_valid", bus.o_rsp_valid, 1'b0);
    @(negedge clk);
    bus.i_mem_ack = 1'b0;
    chk1("stale_ack_rsp_valid", bus.o_rsp_valid, 1'b0);
    chk1("stale_ack_ready", bus.o_req_ready, 1'b1);
    chk1("stale_ack_mem_req", bus.o_mem_req, 1'b0);

    // Illegal funct3.
    txn(1'b0, 3'b011, 32'h0000_4000, 32'd0, 32'd0, 1,
        r_addr, r_be, r_wd, r_we, r_rsp, r_err, r_mis, r_seen);
    chk1("illegal_err", r_err, 1'b1);
    chk1("illegal_noreq", r_seen, 1'b0);

    // Randomized transactions against the model.
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      if (st) f3 = st_tab[$urandom_range(0, 3)];
      else    f3 = ld_tab[$urandom_range(0, 7)];
      rd = $urandom();
      txn(st, f3, $urandom(), $urandom(), rd, int'($urandom_range(0, TO + 1)),
          r_addr, r_be, r_wd, r_we, r_rsp, r_err, r_mis, r_seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
